s_type_encoder: RTL and testbench

- Reverse of the S-type field splitter: packs store-instruction fields (rs1, rs2, func3, 12-bit imm) into 32-bit RV32I S-type words.
- Validates func3 against legal store widths (SB/SH/SW) and buffers encoded words in a small FIFO with valid/ready on both sides.
- Used by the instruction-memory loader and the decode-stage test generator to stream store instructions into the front end.

---
 rtl/s_type_encoder.sv | 130 +++++++++++++
 tb/tb_s_type_encoder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_type_encoder.sv
// rtl/s_type_encoder.sv - packs RV32I S-type store fields into 32-bit words behind a small FIFO
// Optional saturating statistics counters enabled by S_TYPE_ENC_STATS_EN.
module s_type_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [4:0]                      in_rs1,
  input  logic [4:0]                      in_rs2,
  input  logic [2:0]                      in_func3,
  input  logic [11:0]                     in_imm,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [31:0]                     out_instr,
  output logic [CNT_W-1:0]                out_idx,
  output logic                            err_illegal,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
`ifdef S_TYPE_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0]                stat_encoded,
  output logic [CNT_W-1:0]                stat_rejected
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]      instr_mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0] idx_mem_q   [FIFO_DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [CNT_W-1:0] seq_q,    seq_d;
  logic             err_q,    err_d;

  logic        accept, legal, push, pop;
  logic [31:0] word;

  assign in_ready = (count_q < DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign legal    = (in_func3 < 3'd3);
  assign push     = accept && legal;
  assign pop      = out_valid && out_ready;
  assign word     = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], 7'b0100011};

  // Outputs are masked while empty so they read zero in and after reset.
  assign out_valid   = (count_q != '0);
  assign out_instr   = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign out_idx     = out_valid ? idx_mem_q[rd_ptr_q] : '0;
  assign err_illegal = err_q;
  assign fifo_count  = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    seq_d    = seq_q;
    err_d    = accept && !legal;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      seq_d    = seq_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= word;
      idx_mem_q[wr_ptr_q]   <= seq_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      err_q    <= err_d;
    end
  end

`ifdef S_TYPE_ENC_STATS_EN
  logic [CNT_W-1:0] enc_q, enc_d;
  logic [CNT_W-1:0] rej_q, rej_d;

  always_comb begin
    enc_d = enc_q;
    rej_d = rej_q;
    if (push && (enc_q != '1)) begin
      enc_d = enc_q + CNT_W'(1);
    end
    if (accept && !legal && (rej_q != '1)) begin
      rej_d = rej_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_q <= '0;
      rej_q <= '0;
    end else begin
      enc_q <= enc_d;
      rej_q <= rej_d;
    end
  end

  assign stat_encoded  = enc_q;
  assign stat_rejected = rej_q;
`endif

endmodule

// File: tb/tb_s_type_encoder.sv
// tb/tb_s_type_encoder.sv - scoreboard bench for s_type_encoder (CNT_W=3, optional S_TYPE_ENC_STATS_EN)
module tb_s_type_encoder;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [2:0]    in_func3 = '0;
  logic [11:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [CW-1:0] out_idx;
  logic          err_illegal;
  logic [2:0]    fifo_count;
`ifdef S_TYPE_ENC_STATS_EN
  logic [CW-1:0] stat_encoded;
  logic [CW-1:0] stat_rejected;
`endif

  s_type_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_func3(in_func3), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_idx(out_idx),
    .err_illegal(err_illegal), .fifo_count(fifo_count)
`ifdef S_TYPE_ENC_STATS_EN
    , .stat_encoded(stat_encoded), .stat_rejected(stat_rejected)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   instr;
    logic [CW-1:0] idx;
  } exp_t;

  exp_t          sb_q[$];
  logic [CW-1:0] exp_seq = '0;
  int            checks = 0;
  int            failures = 0;
  int            n_popped = 0;

  function automatic logic [31:0] encode(input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got instr=%h idx=%0d, expected no word", out_instr, out_idx);
      end else begin
        e = sb_q.pop_front();
        n_popped++;
        if (out_instr !== e.instr || out_idx !== e.idx) begin
          failures++;
          $display("FAIL sb_word: got instr=%h idx=%0d, expected instr=%h idx=%0d",
                   out_instr, out_idx, e.instr, e.idx);
        end
      end
    end
  end

  task automatic push(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [11:0] imm);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_func3 = f3; in_imm = imm;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL push_timeout: in_ready=%b, expected 1", in_ready);
    end
    @(posedge clk);
    if (f3 < 3'd3) begin
      sb_q.push_back({encode(rs1, rs2, f3, imm), exp_seq});
      exp_seq = exp_seq + 1'b1;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || fifo_count != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL drain: pending=%0d fifo_count=%0d, expected 0 and 0", sb_q.size(), fifo_count);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (fifo_count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_instr !== 32'h0 || out_idx !== 3'd0 || err_illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: cnt=%0d ov=%b ir=%b instr=%h idx=%0d err=%b, expected 0 0 1 0 0 0",
               fifo_count, out_valid, in_ready, out_instr, out_idx, err_illegal);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push(5'd2, 5'd5, 3'd2, 12'hFFC);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFE512E23 || out_idx !== 3'd0) begin
      failures++;
      $display("FAIL basic_sw: ov=%b instr=%h idx=%0d, expected 1 fe512e23 0", out_valid, out_instr, out_idx);
    end
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL basic_count: fifo_count=%0d, expected 0", fifo_count);
    end
    push(5'd0, 5'd0, 3'd0, 12'h000);
    @(negedge clk);
    checks++;
    if (out_instr !== 32'h00000023 || out_idx !== 3'd1) begin
      failures++;
      $display("FAIL basic_sb: instr=%h idx=%0d, expected 00000023 1", out_instr, out_idx);
    end
    wait_drain();
  endtask

  task automatic test_illegal();
    push(5'd1, 5'd1, 3'd3, 12'h005);
    @(negedge clk);
    checks++;
    if (err_illegal !== 1'b1 || out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL illegal_pulse: err=%b ov=%b cnt=%0d, expected 1 0 0", err_illegal, out_valid, fifo_count);
    end
    @(negedge clk);
    checks++;
    if (err_illegal !== 1'b0) begin
      failures++;
      $display("FAIL illegal_clear: err=%b, expected 0", err_illegal);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_func3 = 3'd5;
    @(posedge clk); #1 in_func3 = 3'd7;
    @(negedge clk);
    checks++;
    if (err_illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_b2b_1: err=%b, expected 1", err_illegal);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err_illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_b2b_2: err=%b, expected 1", err_illegal);
    end
    @(negedge clk);
    checks++;
    if (err_illegal !== 1'b0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL illegal_b2b_end: err=%b cnt=%0d, expected 0 0", err_illegal, fifo_count);
    end
    push(5'd3, 5'd4, 3'd1, 12'h010);
    @(negedge clk);
    checks++;
    if (out_idx !== 3'd2) begin
      failures++;
      $display("FAIL illegal_idx: idx=%0d, expected 2", out_idx);
    end
`ifdef S_TYPE_ENC_STATS_EN
    checks++;
    if (stat_rejected !== 3'd3 || stat_encoded !== 3'd3) begin
      failures++;
      $display("FAIL stats_illegal: rej=%0d enc=%0d, expected 3 3", stat_rejected, stat_encoded);
    end
`endif
    wait_drain();
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(5'(i + 1), 5'(i + 10), 3'(i % 3), 12'(i * 291 + 7));
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_rs1 = 5'd31; in_rs2 = 5'd30; in_func3 = 3'd2; in_imm = 12'h800;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || fifo_count !== 3'd4 || out_valid !== 1'b1 ||
          out_instr !== sb_q[0].instr || out_idx !== sb_q[0].idx) begin
        failures++;
        $display("FAIL full_stall: ir=%b cnt=%0d instr=%h idx=%0d, expected 0 4 %h %0d",
                 in_ready, fifo_count, out_instr, out_idx, sb_q[0].instr, sb_q[0].idx);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    push(5'd31, 5'd30, 3'd2, 12'h800);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(5'(i), 5'(i + 3), 3'd0, 12'(i + 100));
    end
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd3) begin
      failures++;
      $display("FAIL mid_fill: fifo_count=%0d, expected 3", fifo_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: ov=%b cnt=%0d ir=%b, expected 0 0 1", out_valid, fifo_count, in_ready);
    end
`ifdef S_TYPE_ENC_STATS_EN
    checks++;
    if (stat_encoded !== 3'd0 || stat_rejected !== 3'd0) begin
      failures++;
      $display("FAIL stats_reset: enc=%0d rej=%0d, expected 0 0", stat_encoded, stat_rejected);
    end
`endif
    #1 rst = 1'b0;
    sb_q.delete();
    exp_seq = '0;
    @(posedge clk); #1 out_ready = 1'b1;
    push(5'd7, 5'd8, 3'd2, 12'h123);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0) begin
      failures++;
      $display("FAIL mid_idx: ov=%b idx=%0d, expected 1 0", out_valid, out_idx);
    end
    wait_drain();
  endtask

  task automatic test_wrap();
    int start;
    @(negedge clk); #2 rst = 1'b1;
    #2 rst = 1'b0;
    sb_q.delete();
    exp_seq = '0;
    start = n_popped;
    for (int i = 0; i < 9; i++) begin
      push(5'($urandom_range(31)), 5'($urandom_range(31)), 3'($urandom_range(2)), 12'($urandom_range(4095)));
    end
    wait_drain();
    checks++;
    if (n_popped - start != 9) begin
      failures++;
      $display("FAIL wrap_count: popped=%0d, expected 9", n_popped - start);
    end
`ifdef S_TYPE_ENC_STATS_EN
    checks++;
    if (stat_encoded !== 3'd7) begin
      failures++;
      $display("FAIL stats_sat: enc=%0d, expected 7", stat_encoded);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
